// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, issues imem requests and slices the fetched word into decoder fields.
module fetch_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_f3,
    output logic            id_f7,
    output logic [24:0]     id_immSample,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] fetch_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    // Priority: redirect > stall > ready > wait; a redirect drops any word returned this cycle.
    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (stall) begin
            // hold everything
        end else if (imem_ready) begin
            pc_d          = pc_q + XLEN'(4);
            id_pc_d       = pc_q;
            id_instr_d    = imem_rdata;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + XLEN'(1);
        end else begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC[XLEN-1:0];
            id_pc_q       <= '0;
            id_instr_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req     = ~rst & ~stall & ~redirect_valid;
    assign imem_addr    = pc_q;
    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_instr     = id_instr_q;
    assign fetch_count  = fetch_count_q;

    assign id_opcode    = id_instr_q[6:0];
    assign id_f3        = id_instr_q[14:12];
    assign id_f7        = id_instr_q[30];
    assign id_immSample = id_instr_q[31:7];
    assign id_rs1       = id_instr_q[19:15];
    assign id_rs2       = id_instr_q[24:20];
    assign id_rd        = id_instr_q[11:7];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect, wait states, PC wrap, reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc, id_instr, fetch_count;
    logic [6:0]  id_opcode;
    logic [2:0]  id_f3;
    logic        id_f7;
    logic [24:0] id_immSample;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        ovr_en;
    logic [31:0] ovr_word;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Memory returns word == address unless a specific word is forced.
    assign imem_rdata = ovr_en ? ovr_word : imem_addr;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_f3(id_f3), .id_f7(id_f7),
        .id_immSample(id_immSample), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .fetch_count(fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h id_valid=%0b id_pc=%h id_instr=%h count=%0d req=%0b",
                 $time, imem_addr, id_valid, id_pc, id_instr, fetch_count, imem_req);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; ovr_en = 1'b0; ovr_word = '0;
        step(); step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 32'h13); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_after_reset got=%b exp=1", imem_req); end
    endtask

    task automatic test_stream();
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (id_pc !== 32'(4*i)) begin errors++; $display("FAIL stream_id_pc[%0d] got=%h exp=%h", i, id_pc, 32'(4*i)); end
            checks++; if (id_instr !== 32'(4*i)) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, id_instr, 32'(4*i)); end
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, id_valid); end
            checks++; if (fetch_count !== 32'(i+1)) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, fetch_count, i+1); end
            checks++; if (imem_addr !== 32'(4*i+4)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, imem_addr, 32'(4*i+4)); end
        end
    endtask

    task automatic test_stall();
        // Load 0x00A00093 from address 0x18 so the held word is distinctive.
        ovr_en = 1'b1; ovr_word = 32'h00A0_0093;
        step();
        ovr_en = 1'b0;
        checks++; if (id_instr !== 32'h00A0_0093) begin errors++; $display("FAIL stall_setup got=%h exp=%h", id_instr, 32'h00A0_0093); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
            step();
            checks++; if (imem_addr !== 32'h1C) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, imem_addr, 32'h1C); end
            checks++; if (id_instr !== 32'h00A0_0093) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, id_instr, 32'h00A0_0093); end
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, id_valid); end
            checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=7", i, fetch_count); end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;   // stall still 1
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got=%b exp=0", imem_req); end
        step();
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_pc got=%h exp=%h", imem_addr, 32'h100); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL redir_instr got=%h exp=%h", id_instr, 32'h13); end
        checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL redir_count got=%0d exp=7", fetch_count); end
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL redir_next_id_pc got=%h exp=%h", id_pc, 32'h100); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL redir_next_valid got=%b exp=1", id_valid); end
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL redir_next_count got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_redirect_with_ready();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;   // imem_ready still 1
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rr_pc got=%h exp=%h", imem_addr, 32'h20); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got=%b exp=0", id_valid); end
        checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL rr_count got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, id_valid); end
            checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL wait_instr[%0d] got=%h exp=%h", i, id_instr, 32'h13); end
            checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL wait_pc[%0d] got=%h exp=%h", i, imem_addr, 32'h20); end
        end
        imem_ready = 1'b1;
        step();
        checks++; if (id_pc !== 32'h20) begin errors++; $display("FAIL wait_id_pc got=%h exp=%h", id_pc, 32'h20); end
        checks++; if (id_instr !== 32'h20) begin errors++; $display("FAIL wait_id_instr got=%h exp=%h", id_instr, 32'h20); end
        checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL wait_next_pc got=%h exp=%h", imem_addr, 32'h24); end
        checks++; if (fetch_count !== 32'd9) begin errors++; $display("FAIL wait_count got=%0d exp=9", fetch_count); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;   // low bits must be dropped
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_id_pc got=%h exp=%h", id_pc, 32'hFFFF_FFFC); end
        checks++; if (fetch_count !== 32'd10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", fetch_count); end
    endtask

    task automatic test_reset_mid_and_decode();
        rst = 1'b1; imem_ready = 1'b0;
        step();
        rst = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ovr_en = (i == 4); ovr_word = 32'h0060_0513;
            step();
        end
        ovr_en = 1'b0;
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL mid_count got=%0d exp=5", fetch_count); end
        checks++; if (id_opcode !== 7'h13) begin errors++; $display("FAIL dec_opcode got=%h exp=13", id_opcode); end
        checks++; if (id_f3 !== 3'd0) begin errors++; $display("FAIL dec_f3 got=%0d exp=0", id_f3); end
        checks++; if (id_f7 !== 1'b0) begin errors++; $display("FAIL dec_f7 got=%b exp=0", id_f7); end
        checks++; if (id_rd !== 5'd10) begin errors++; $display("FAIL dec_rd got=%0d exp=10", id_rd); end
        checks++; if (id_rs1 !== 5'd0) begin errors++; $display("FAIL dec_rs1 got=%0d exp=0", id_rs1); end
        checks++; if (id_rs2 !== 5'd6) begin errors++; $display("FAIL dec_rs2 got=%0d exp=6", id_rs2); end
        checks++; if (id_immSample !== 25'h000_C00A) begin errors++; $display("FAIL dec_imm got=%h exp=%h", id_immSample, 25'h000_C00A); end
        stall = 1'b1; rst = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got=%h exp=0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", id_valid); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", fetch_count); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL mid_rst_instr got=%h exp=%h", id_instr, 32'h13); end
        rst = 1'b0; stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL restart_id_pc got=%h exp=0", id_pc); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL restart_count got=%0d exp=1", fetch_count); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL restart_pc got=%h exp=4", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_with_ready();
        test_wait();
        test_wrap();
        test_reset_mid_and_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
